// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants (640x480 @ 60 Hz defaults) and coordinate types,
// reused by the timing generator and the pattern generators.
package vga_timing_pkg;

    localparam int unsigned COORD_W = 10;
    localparam int unsigned RGB_W   = 6;
    localparam int unsigned FRAME_W = 8;

    typedef logic [COORD_W-1:0] coord_t;
    typedef logic [RGB_W-1:0]   rgb_t;
    typedef logic [FRAME_W-1:0] frame_t;

    localparam int unsigned DEF_H_VISIBLE = 640;
    localparam int unsigned DEF_H_FRONT   = 16;
    localparam int unsigned DEF_H_SYNC    = 96;
    localparam int unsigned DEF_H_BACK    = 48;

    localparam int unsigned DEF_V_VISIBLE = 480;
    localparam int unsigned DEF_V_FRONT   = 10;
    localparam int unsigned DEF_V_SYNC    = 2;
    localparam int unsigned DEF_V_BACK    = 33;

    function automatic int unsigned axis_total(input int unsigned visible,
                                               input int unsigned front,
                                               input int unsigned sync,
                                               input int unsigned back);
        return visible + front + sync + back;
    endfunction

    localparam int unsigned DEF_H_TOTAL =
        axis_total(DEF_H_VISIBLE, DEF_H_FRONT, DEF_H_SYNC, DEF_H_BACK);
    localparam int unsigned DEF_V_TOTAL =
        axis_total(DEF_V_VISIBLE, DEF_V_FRONT, DEF_V_SYNC, DEF_V_BACK);

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: wrap counter with enable, carry-out on wrap, and decode of
// the visible region and the active-low sync window.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int unsigned VISIBLE = DEF_H_VISIBLE,
    parameter int unsigned FRONT   = DEF_H_FRONT,
    parameter int unsigned SYNC    = DEF_H_SYNC,
    parameter int unsigned BACK    = DEF_H_BACK
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    output logic [COORD_W-1:0] count,
    output logic               carry,
    output logic               visible,
    output logic               sync_n
);

    localparam int unsigned TOTAL   = axis_total(VISIBLE, FRONT, SYNC, BACK);
    localparam coord_t      LAST_C  = coord_t'(TOTAL - 1);
    localparam coord_t      VIS_C   = coord_t'(VISIBLE);
    localparam coord_t      SYNC_LO = coord_t'(VISIBLE + FRONT);
    localparam coord_t      SYNC_HI = coord_t'(VISIBLE + FRONT + SYNC);

    logic last;

    assign last = (count == LAST_C);

    // Wrap is decided before the add, so the count never leaves COORD_W bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (en) begin
            count <= last ? '0 : count + coord_t'(1);
        end
    end

    assign carry   = en && last;
    assign visible = (count < VIS_C);
    assign sync_n  = !((count >= SYNC_LO) && (count < SYNC_HI));

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: H/V counters, frame strobe and counter, and a one-pixel
// output register stage aligning syncs with the blanked pattern colour.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int unsigned H_VISIBLE = DEF_H_VISIBLE,
    parameter int unsigned H_FRONT   = DEF_H_FRONT,
    parameter int unsigned H_SYNC    = DEF_H_SYNC,
    parameter int unsigned H_BACK    = DEF_H_BACK,
    parameter int unsigned V_VISIBLE = DEF_V_VISIBLE,
    parameter int unsigned V_FRONT   = DEF_V_FRONT,
    parameter int unsigned V_SYNC    = DEF_V_SYNC,
    parameter int unsigned V_BACK    = DEF_V_BACK
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               pix_ce,
    input  logic [RGB_W-1:0]   rgb_in,
    output logic [COORD_W-1:0] x,
    output logic [COORD_W-1:0] y,
    output logic               active,
    output logic               next_frame,
    output logic [FRAME_W-1:0] frame_count,
    output logic               hsync,
    output logic               vsync,
    output logic [RGB_W-1:0]   rgb_out
);

    localparam coord_t V_VIS_C = coord_t'(V_VISIBLE);

    logic h_carry;
    logic v_carry;
    logic h_visible;
    logic v_visible;
    logic h_sync_raw;
    logic v_sync_raw;

    vga_axis_counter #(
        .VISIBLE(H_VISIBLE),
        .FRONT  (H_FRONT),
        .SYNC   (H_SYNC),
        .BACK   (H_BACK)
    ) u_h_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (pix_ce),
        .count  (x),
        .carry  (h_carry),
        .visible(h_visible),
        .sync_n (h_sync_raw)
    );

    // The vertical axis steps only on the horizontal wrap, so its carry marks
    // the edge that returns both axes to 0,0.
    vga_axis_counter #(
        .VISIBLE(V_VISIBLE),
        .FRONT  (V_FRONT),
        .SYNC   (V_SYNC),
        .BACK   (V_BACK)
    ) u_v_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .en     (h_carry),
        .count  (y),
        .carry  (v_carry),
        .visible(v_visible),
        .sync_n (v_sync_raw)
    );

    assign active     = h_visible && v_visible;
    assign next_frame = pix_ce && (x == '0) && (y == V_VIS_C);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_count <= '0;
        end else if (v_carry) begin
            frame_count <= frame_count + frame_t'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync   <= 1'b1;
            vsync   <= 1'b1;
            rgb_out <= '0;
        end else if (pix_ce) begin
            hsync   <= h_sync_raw;
            vsync   <= v_sync_raw;
            rgb_out <= active ? rgb_in : '0;
        end
    end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a reduced raster (15 x 10) so many frames fit a
// short run; expectations come from a pixel-index model of the raster.
module tb_vga_timing_gen;

    localparam int HV = 8, HF = 2, HS = 3, HB = 2;
    localparam int VV = 6, VF = 1, VS = 2, VB = 1;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int FRAME = HT * VT;

    // ---------------- clock / reset / DUT ----------------
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pix_ce = 1'b0;
    logic [5:0] rgb_in = '0;
    logic [9:0] x, y;
    logic       active, next_frame;
    logic [7:0] frame_count;
    logic       hsync, vsync;
    logic [5:0] rgb_out;

    always #5 clk = ~clk;

    vga_timing_gen #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pix_ce     (pix_ce),
        .rgb_in     (rgb_in),
        .x          (x),
        .y          (y),
        .active     (active),
        .next_frame (next_frame),
        .frame_count(frame_count),
        .hsync      (hsync),
        .vsync      (vsync),
        .rgb_out    (rgb_out)
    );

    wire [36:0] dut_bus = {x, y, frame_count, hsync, vsync, rgb_out, active};

    // ---------------- reference model ----------------
    int         checks = 0;
    int         errors = 0;
    int         n = 0;              // pixel-clock-enable edges since reset
    logic       exp_hs = 1'b1;
    logic       exp_vs = 1'b1;
    logic [5:0] exp_rgb = '0;
    logic [5:0] exp_q[$];

    function automatic int ex_x();
        return n % HT;
    endfunction

    function automatic int ex_y();
        return (n / HT) % VT;
    endfunction

    function automatic int ex_fc();
        return (n / FRAME) % 256;
    endfunction

    function automatic bit in_win(input int v, input int lo, input int w);
        return (v >= lo) && (v < lo + w);
    endfunction

    function automatic logic [36:0] model_bus();
        logic act;
        act = (ex_x() < HV) && (ex_y() < VV);
        return {10'(ex_x()), 10'(ex_y()), 8'(ex_fc()), exp_hs, exp_vs, exp_rgb, act};
    endfunction

    // ---------------- next_frame monitor ----------------
    int         cyc = 0;
    int         nf_cnt = 0;
    int         nf_last = 0;
    int         nf_period = 0;
    int         nf_run = 0;
    int         nf_max_run = 0;
    int         nf_bad_ce = 0;
    logic [9:0] nf_x = '0;
    logic [9:0] nf_y = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (next_frame) begin
            nf_cnt    <= nf_cnt + 1;
            nf_x      <= x;
            nf_y      <= y;
            nf_period <= cyc - nf_last;
            nf_last   <= cyc;
            nf_run    <= nf_run + 1;
            if (nf_run + 1 > nf_max_run) nf_max_run <= nf_run + 1;
            if (!pix_ce) nf_bad_ce <= nf_bad_ce + 1;
        end else begin
            nf_run <= 0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input bit ce, input logic [5:0] rgb);
        int mx, my;
        @(negedge clk);
        pix_ce = ce;
        rgb_in = rgb;
        if (ce) begin
            mx = n % HT;
            my = (n / HT) % VT;
            exp_hs = !in_win(mx, HV + HF, HS);
            exp_vs = !in_win(my, VV + VF, VS);
            exp_q.push_back(((mx < HV) && (my < VV)) ? rgb : 6'd0);
            n++;
        end
        @(posedge clk);
        #1;
        if (exp_q.size() > 0) exp_rgb = exp_q.pop_front();
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        pix_ce = 1'b0;
        rgb_in = '0;
        repeat (2) @(negedge clk);
        n = 0;
        exp_hs = 1'b1;
        exp_vs = 1'b1;
        exp_rgb = '0;
        exp_q.delete();
        rst_n = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        @(negedge clk);
        rst_n  = 1'b0;
        pix_ce = 1'b1;
        rgb_in = 6'h3F;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({x, y, frame_count} !== 28'd0) begin
            errors++;
            $display("FAIL reset_counters: got x=%0d y=%0d fc=%0d, want 0 0 0", x, y, frame_count);
        end
        checks++;
        if ({hsync, vsync, rgb_out} !== {1'b1, 1'b1, 6'd0}) begin
            errors++;
            $display("FAIL reset_outputs: got hs=%b vs=%b rgb=%h, want 1 1 00", hsync, vsync, rgb_out);
        end
        checks++;
        if (next_frame !== 1'b0) begin
            errors++;
            $display("FAIL reset_next_frame: got %b want 0", next_frame);
        end
        apply_reset();
        step(1'b1, 6'h15);
        checks++;
        if ({x, y} !== {10'd1, 10'd0}) begin
            errors++;
            $display("FAIL first_advance: got x=%0d y=%0d want 1 0", x, y);
        end
    endtask

    task automatic test_line();
        int hs_low = 0;
        apply_reset();
        for (int i = 0; i < HT; i++) begin
            step(1'b1, 6'($urandom_range(0, 63)));
            if (hsync === 1'b0) hs_low++;
            checks++;
            if (dut_bus !== model_bus()) begin
                errors++;
                $display("FAIL line_state step %0d: got %h want %h", i, dut_bus, model_bus());
            end
        end
        checks++;
        if ({x, y} !== {10'd0, 10'd1}) begin
            errors++;
            $display("FAIL line_wrap: got x=%0d y=%0d want 0 1", x, y);
        end
        checks++;
        if (hs_low != HS) begin
            errors++;
            $display("FAIL hsync_width: got %0d want %0d", hs_low, HS);
        end
    endtask

    // Continues from the end of test_line to complete the first frame.
    task automatic test_frame();
        int base = nf_cnt;
        for (int i = HT; i < FRAME; i++) begin
            step(1'b1, 6'($urandom_range(0, 63)));
            checks++;
            if (dut_bus !== model_bus()) begin
                errors++;
                $display("FAIL frame_state n=%0d: got %h want %h", n, dut_bus, model_bus());
            end
        end
        checks++;
        if ({x, y, frame_count} !== {10'd0, 10'd0, 8'd1}) begin
            errors++;
            $display("FAIL frame_end: got x=%0d y=%0d fc=%0d want 0 0 1", x, y, frame_count);
        end
        checks++;
        if (nf_cnt - base != 1) begin
            errors++;
            $display("FAIL next_frame_count: got %0d want 1", nf_cnt - base);
        end
        checks++;
        if ({nf_x, nf_y} !== {10'd0, 10'(VV)}) begin
            errors++;
            $display("FAIL next_frame_pos: got x=%0d y=%0d want 0 %0d", nf_x, nf_y, VV);
        end
    endtask

    task automatic test_pix_ce_toggle();
        int base;
        apply_reset();
        base = nf_cnt;
        for (int i = 0; i < 4 * FRAME; i++) begin
            step((i % 2) == 0, 6'($urandom_range(0, 63)));
            checks++;
            if (dut_bus !== model_bus()) begin
                errors++;
                $display("FAIL toggle_state clk %0d: got %h want %h", i, dut_bus, model_bus());
            end
        end
        checks++;
        if (nf_cnt - base != 2) begin
            errors++;
            $display("FAIL toggle_nf_count: got %0d want 2", nf_cnt - base);
        end
        checks++;
        if (nf_period != 2 * FRAME) begin
            errors++;
            $display("FAIL toggle_frame_period: got %0d want %0d", nf_period, 2 * FRAME);
        end
        checks++;
        if (nf_max_run != 1 || nf_bad_ce != 0) begin
            errors++;
            $display("FAIL nf_width: got run=%0d while_ce_low=%0d want 1 0", nf_max_run, nf_bad_ce);
        end
    endtask

    task automatic test_rgb_blanking();
        int white = 0;
        apply_reset();
        for (int i = 0; i < FRAME; i++) begin
            step(1'b1, 6'h3F);
            if (rgb_out === 6'h3F) white++;
            checks++;
            if (dut_bus !== model_bus()) begin
                errors++;
                $display("FAIL rgb_state n=%0d: got %h want %h", n, dut_bus, model_bus());
            end
        end
        checks++;
        if (white != HV * VV) begin
            errors++;
            $display("FAIL rgb_active_cycles: got %0d want %0d", white, HV * VV);
        end
    endtask

    task automatic test_frame_wrap();
        int vs_low = 0;
        apply_reset();
        for (int i = 0; i < 256 * FRAME; i++) begin
            step(1'b1, 6'($urandom_range(0, 63)));
            if (i >= 255 * FRAME && vsync === 1'b0) vs_low++;
            checks++;
            if (dut_bus !== model_bus()) begin
                errors++;
                $display("FAIL wrap_state n=%0d: got %h want %h", n, dut_bus, model_bus());
            end
            if (n == 255 * FRAME) begin
                checks++;
                if (frame_count !== 8'd255) begin
                    errors++;
                    $display("FAIL fc_255: got %0d want 255", frame_count);
                end
            end
        end
        checks++;
        if ({x, y, frame_count} !== 28'd0) begin
            errors++;
            $display("FAIL fc_wrap: got x=%0d y=%0d fc=%0d want 0 0 0", x, y, frame_count);
        end
        checks++;
        if (vs_low != VS * HT) begin
            errors++;
            $display("FAIL vsync_width: got %0d want %0d", vs_low, VS * HT);
        end
    endtask

    task automatic test_async_reset();
        int targets[2];
        targets[0] = 2 * HT + 5;             // inside the picture, rgb_out live
        targets[1] = FRAME + 7 * HT + 11;    // in both sync pulses, second frame
        foreach (targets[k]) begin
            apply_reset();
            for (int i = 0; i < targets[k]; i++) step(1'b1, 6'h2A);
            checks++;
            if (dut_bus !== model_bus()) begin
                errors++;
                $display("FAIL pre_reset_state %0d: got %h want %h", k, dut_bus, model_bus());
            end
            #2;
            rst_n = 1'b0;
            #1;
            checks++;
            if ({x, y, frame_count, hsync, vsync, rgb_out, next_frame} !==
                {10'd0, 10'd0, 8'd0, 1'b1, 1'b1, 6'd0, 1'b0}) begin
                errors++;
                $display("FAIL async_reset %0d: got x=%0d y=%0d fc=%0d hs=%b vs=%b rgb=%h nf=%b",
                         k, x, y, frame_count, hsync, vsync, rgb_out, next_frame);
            end
            n = 0;
            exp_hs = 1'b1;
            exp_vs = 1'b1;
            exp_rgb = '0;
            exp_q.delete();
            @(negedge clk);
            pix_ce = 1'b0;
            rst_n = 1'b1;
            step(1'b1, 6'h01);
            checks++;
            if ({x, y} !== {10'd1, 10'd0}) begin
                errors++;
                $display("FAIL restart_after_reset %0d: got x=%0d y=%0d want 1 0", k, x, y);
            end
        end
    endtask

    initial begin
        test_reset();
        test_line();
        test_frame();
        test_pix_ce_toggle();
        test_rgb_blanking();
        test_frame_wrap();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_VISIBLE, 640, visible pixels per line.
REQ-002 Parameter H_FRONT, 16; H_SYNC, 96; H_BACK, 48: horizontal porch and sync widths in pixels.
REQ-003 Parameter V_VISIBLE, 480, visible lines per frame.
REQ-004 Parameter V_FRONT, 10; V_SYNC, 2; V_BACK, 33: vertical porch and sync widths in lines.
REQ-005 clk  input  1  pixel-domain clock.
REQ-006 rst_n  input  1  reset, asynchronous, active-low.
REQ-007 pix_ce  input  1  pixel clock enable; counters advance only when high.
REQ-008 rgb_in  input  6  pattern colour for the current x, y (RRGGBB), combinational from the downstream pattern stage.
REQ-009 x  output  10  current column, 0..H_TOTAL-1.
REQ-010 y  output  10  current line, 0..V_TOTAL-1.
REQ-011 active  output  1  high when x < H_VISIBLE and y < V_VISIBLE.
REQ-012 next_frame  output  1  one-cycle frame-advance strobe.
REQ-013 frame_count  output  8  frames completed, modulo 256.
REQ-014 hsync, vsync  output  1 each  registered sync outputs, active-low.
REQ-015 rgb_out  output  6  registered colour, aligned with hsync/vsync.

Function
REQ-016 H_TOTAL SHALL equal H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL SHALL equal the vertical sum (525).
REQ-017 On a clk edge with pix_ce high, x SHALL increment; at x = H_TOTAL-1, x SHALL wrap to 0 and y SHALL increment.
REQ-018 At x = H_TOTAL-1 and y = V_TOTAL-1 with pix_ce high, both x and y SHALL wrap to 0 on the same edge.
REQ-019 With pix_ce low, x, y, frame_count and all registered outputs SHALL hold.
REQ-020 active SHALL be combinational from the x and y registers.
REQ-021 next_frame SHALL be high for exactly one clk cycle, in the cycle where x = 0, y = V_VISIBLE and pix_ce is high; it SHALL be low otherwise, including while pix_ce is low.
REQ-022 frame_count SHALL increment, wrapping 255->0, on the same edge that takes x and y to 0,0.
REQ-023 Internal raw hsync SHALL be low when H_VISIBLE+H_FRONT <= x < H_VISIBLE+H_FRONT+H_SYNC, i.e. 656..751.
REQ-024 Internal raw vsync SHALL be low when V_VISIBLE+V_FRONT <= y < V_VISIBLE+V_FRONT+V_SYNC, i.e. 490..491, for the full line width.
REQ-025 Output stage: on pix_ce, hsync, vsync and rgb_out SHALL register the raw syncs and (active ? rgb_in : 0), giving one pix_ce-cycle latency versus x/y.
REQ-026 rgb_out SHALL be 0 whenever the registered pixel was outside the active region, regardless of rgb_in.
REQ-027 Counters SHALL be sized so no intermediate value exceeds 10 bits; no arithmetic overflow is permitted for legal parameters.

Reset
REQ-028 While rst_n is low: x=0, y=0, frame_count=0, hsync=1, vsync=1, rgb_out=0.
REQ-029 next_frame SHALL be low during reset; reset assertion mid-line or mid-frame SHALL take effect asynchronously, without waiting for clk.
REQ-030 After rst_n deasserts, the first pix_ce edge SHALL advance x from 0 to 1.

Structure
REQ-031 H/V timing constants and derived totals SHALL live in a shared package (vga_timing_pkg), reused by the pattern generators.
REQ-032 One sub-module is natural: vga_axis_counter, a parameterised wrap counter with enable, carry-out and a sync-window compare, instantiated once for H and once for V.
REQ-033 The output register stage SHALL stay in the top module.

Verification
REQ-034 Reset, then 800 pix_ce cycles -> x returns to 0, y=1; hsync low exactly for registered x 656..751, 96 cycles.
REQ-035 Run one full frame (420000 pix_ce cycles) -> x=0, y=0, frame_count=1; exactly one next_frame pulse, at x=0, y=480.
REQ-036 pix_ce toggling 1/0 -> counters advance every other clk; next_frame is one clk wide; frame period is 840000 clk.
REQ-037 Drive rgb_in=6'b111111 constantly -> rgb_out=6'b111111 only one cycle after active, and 0 during blanking and at x=640.
REQ-038 Preload frame_count to 255 by running 256 frames -> it wraps to 0; vsync low for lines 490..491 only.
REQ-039 Assert rst_n low mid-frame (x=300, y=200) -> outputs reach reset values immediately; after release, counting restarts from 0,0.
